// File: rtl/husky_requester.sv
// HuskyLens request-frame builder and 8N1 UART serialiser.
// Frame: 55 AA 11 len cmd payload[0..len-1] checksum.
module husky_requester #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int MAX_LEN      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_start,
    input  logic [7:0]  req_cmd,
    input  logic [2:0]  req_len,
    input  logic [31:0] req_data,
    output logic        req_busy,
    output logic        req_done,
    output logic        tx_husky
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [2:0]    len_q, len_d;
    logic [31:0]   data_q, data_d;
    logic          tx_q, tx_d;

    logic [3:0]    last_idx;
    logic          cnt_end;
    logic [7:0]    cur_byte;

    assign last_idx = 4'd5 + {1'b0, len_q};
    assign cnt_end  = (cnt_q == CNT_MAX);

    // Byte at the current frame index; the last index carries the checksum.
    always_comb begin
        cur_byte = 8'h00;
        if (idx_q == last_idx) begin
            cur_byte = sum_q;
        end else begin
            case (idx_q)
                4'd0:    cur_byte = 8'h55;
                4'd1:    cur_byte = 8'hAA;
                4'd2:    cur_byte = 8'h11;
                4'd3:    cur_byte = {5'b0, len_q};
                4'd4:    cur_byte = cmd_q;
                4'd5:    cur_byte = data_q[7:0];
                4'd6:    cur_byte = data_q[15:8];
                4'd7:    cur_byte = data_q[23:16];
                4'd8:    cur_byte = data_q[31:24];
                default: cur_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        data_d  = data_q;
        tx_d    = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (req_start) begin
                    cmd_d   = req_cmd;
                    len_d   = (req_len > LEN_MAX) ? LEN_MAX : req_len;
                    data_d  = req_data;
                    sum_d   = 8'h00;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sh_d = cur_byte;
                if (idx_q != last_idx) begin
                    sum_d = sum_q + cur_byte;
                end
                cnt_d   = '0;
                state_d = S_START;
            end
            S_START: begin
                tx_d = 1'b0;
                if (cnt_end) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                tx_d = sh_q[bit_q];
                if (cnt_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (idx_q == last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            idx_q   <= 4'd0;
            sh_q    <= 8'h00;
            sum_q   <= 8'h00;
            cmd_q   <= 8'h00;
            len_q   <= 3'd0;
            data_q  <= 32'h0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    assign req_busy = (state_q == S_LOAD) || (state_q == S_START) ||
                      (state_q == S_DATA) || (state_q == S_STOP);
    assign req_done = (state_q == S_DONE);
    assign tx_husky = tx_q;

endmodule

// File: tb/tb_husky_requester.sv
// Bench for husky_requester: UART RX monitor plus frame reference model.
module tb_husky_requester;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_start = 1'b0;
    logic [7:0]  req_cmd = 8'h00;
    logic [2:0]  req_len = 3'd0;
    logic [31:0] req_data = 32'h0;
    logic        req_busy;
    logic        req_done;
    logic        tx_husky;

    husky_requester #(.CLKS_PER_BIT(CPB), .MAX_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_start (req_start),
        .req_cmd   (req_cmd),
        .req_len   (req_len),
        .req_data  (req_data),
        .req_busy  (req_busy),
        .req_done  (req_done),
        .tx_husky  (tx_husky)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int frm_err = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (req_busy) busy_cnt++;
        if (req_done) done_cnt++;
    end

    // UART receiver: mid-bit sampling, drops bytes cut by reset.
    initial begin
        logic [7:0] b;
        bit abort;
        bit bad;
        forever begin
            @(negedge clk);
            if (tx_husky === 1'b0) begin
                abort = 0;
                bad = 0;
                b = 8'h00;
                repeat (2) begin
                    @(negedge clk);
                    if (rst) abort = 1;
                end
                if (tx_husky !== 1'b0) bad = 1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (rst) abort = 1;
                    end
                    b[i] = tx_husky;
                end
                repeat (CPB) begin
                    @(negedge clk);
                    if (rst) abort = 1;
                end
                if (tx_husky !== 1'b1) bad = 1;
                if (!abort) begin
                    if (bad) frm_err++;
                    rxq.push_back(b);
                end
            end
        end
    end

    task automatic build(input logic [7:0] c, input int l,
                         input logic [31:0] d);
        int n;
        int s;
        n = (l > 4) ? 4 : l;
        expq.delete();
        expq.push_back(8'h55);
        expq.push_back(8'hAA);
        expq.push_back(8'h11);
        expq.push_back(8'(n));
        expq.push_back(c);
        for (int i = 0; i < n; i++) expq.push_back(8'((d >> (8 * i)) & 255));
        s = 0;
        foreach (expq[i]) s += int'(expq[i]);
        expq.push_back(8'(s % 256));
    endtask

    task automatic launch(input logic [7:0] c, input logic [2:0] l,
                          input logic [31:0] d);
        rxq.delete();
        busy_cnt = 0;
        done_cnt = 0;
        frm_err = 0;
        req_cmd = c;
        req_len = l;
        req_data = d;
        req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        req_cmd = ~c;
        req_len = 3'd0;
        req_data = ~d;
        chk("acc_busy", 32'(req_busy), 1);
        chk("acc_tx", 32'(tx_husky), 1);
        @(negedge clk);
        chk("pre_start_tx", 32'(tx_husky), 1);
        @(negedge clk);
        chk("start_bit_tx", 32'(tx_husky), 0);
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (req_done) seen = 1;
        end
        chk("done_seen", 32'(seen), 1);
    endtask

    task automatic post_checks(input string tag);
        int n;
        n = expq.size();
        repeat (6) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_busy_cyc"}, busy_cnt, n * (10 * CPB + 1));
        chk({tag, "_nbytes"}, rxq.size(), n);
        chk({tag, "_framing"}, frm_err, 0);
        for (int i = 0; i < n && i < rxq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
        chk({tag, "_idle_tx"}, 32'(tx_husky), 1);
        chk({tag, "_idle_busy"}, 32'(req_busy), 0);
    endtask

    task automatic frame(input string tag, input logic [7:0] c,
                         input logic [2:0] l, input logic [31:0] d);
        build(c, int'(l), d);
        launch(c, l, d);
        wait_done();
        post_checks(tag);
    endtask

    initial begin
        logic [7:0]  rc;
        logic [2:0]  rl;
        logic [31:0] rd;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_husky), 1);
        chk("rst_busy", 32'(req_busy), 0);
        chk("rst_done", 32'(req_done), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        frame("knock", 8'h2C, 3'd0, 32'h0);
        frame("request", 8'h20, 3'd0, 32'h0);
        frame("algo", 8'h2D, 3'd2, 32'h0000_0001);
        frame("clamp", 8'hFF, 3'd7, 32'hFFFF_FFFF);

        // Start while busy is ignored.
        build(8'h2D, 3, 32'h00A1_B2C3);
        launch(8'h2D, 3'd3, 32'h00A1_B2C3);
        repeat (100) @(negedge clk);
        req_cmd = 8'h20;
        req_len = 3'd1;
        req_data = 32'h55;
        req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        wait_done();
        // Start in the DONE cycle is ignored.
        req_cmd = 8'h2C;
        req_len = 3'd0;
        req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        chk("done_cyc_ignored", 32'(req_busy), 0);
        post_checks("midbusy");

        // Start one cycle after DONE is accepted.
        build(8'h2C, 0, 32'h0);
        launch(8'h2C, 3'd0, 32'h0);
        wait_done();
        @(negedge clk);
        build(8'h20, 1, 32'h0000_0077);
        launch(8'h20, 3'd1, 32'h0000_0077);
        wait_done();
        post_checks("after_done");

        // Reset during DATA of byte 3.
        build(8'h2D, 4, 32'h1234_5678);
        launch(8'h2D, 3'd4, 32'h1234_5678);
        repeat (3 * (10 * CPB + 1) + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 32'(tx_husky), 1);
        chk("midrst_busy", 32'(req_busy), 0);
        chk("midrst_done", 32'(req_done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_idle", 32'(req_busy), 0);
        frame("knock_after_rst", 8'h2C, 3'd0, 32'h0);

        for (int k = 0; k < 6; k++) begin
            rc = 8'($urandom);
            rl = 3'($urandom_range(0, 7));
            rd = $urandom;
            frame($sformatf("rand%0d", k), rc, rl, rd);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
